// File: rtl/intpol2_d4_sched_if.sv
// Scheduler <-> channel banks / intpol2_D4 core signal bundle.
// master = scheduler side, slave = channels plus core.
interface intpol2_d4_sched_if #(
  parameter int N_CH  = 2,
  parameter int LEN_W = 16
);
  logic [N_CH-1:0]       req;
  logic [N_CH-1:0]       cfg_mode;
  logic [N_CH-1:0]       cfg_bypass;
  logic [N_CH*LEN_W-1:0] cfg_len;
  logic                  core_busy;
  logic                  core_done;
  logic [N_CH-1:0]       gnt;
  logic [N_CH-1:0]       ack;
  logic [N_CH-1:0]       err;
  logic                  core_start;
  logic                  core_mode;
  logic                  core_bypass;
  logic [LEN_W-1:0]      core_len;
  logic                  core_flush;

  modport master (
    input  req, cfg_mode, cfg_bypass, cfg_len, core_busy, core_done,
    output gnt, ack, err, core_start, core_mode, core_bypass, core_len, core_flush
  );
  modport slave (
    output req, cfg_mode, cfg_bypass, cfg_len, core_busy, core_done,
    input  gnt, ack, err, core_start, core_mode, core_bypass, core_len, core_flush
  );
endinterface

// File: rtl/intpol2_d4_sched.sv
// Round-robin job scheduler time-sharing one intpol2_D4 core between N_CH channels.
// Define INTPOL2_SCHED_WDOG_EN to add the accelerator-job watchdog (TMO cycles in RUN).
module intpol2_d4_sched #(
  parameter int N_CH  = 2,
  parameter int LEN_W = 16,
  parameter int QUANT = 1024,
  parameter int TMO   = 4096
) (
  input  logic                clk,
  input  logic                rst,
  intpol2_d4_sched_if.master  bus
);
  localparam int MAXC = (QUANT > TMO) ? QUANT : TMO;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int PW   = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {IDLE, START, WAIT_BSY, RUN, FLUSH, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic          pick_vld;
  logic [CW-1:0] cnt;
  logic          err_flag;
  logic          own_req;
  logic          other_req;

  // Scan from farthest to nearest after ptr so the nearest requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % N_CH);
      if (bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  assign own_req   = |(bus.req & bus.gnt);
  assign other_req = |(bus.req & ~bus.gnt);

  // The core shares rst with this block, so a mid-job reset clears both together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= PW'(N_CH - 1);
      cnt             <= '0;
      err_flag        <= 1'b0;
      bus.gnt         <= '0;
      bus.ack         <= '0;
      bus.err         <= '0;
      bus.core_start  <= 1'b0;
      bus.core_flush  <= 1'b0;
      bus.core_mode   <= 1'b0;
      bus.core_bypass <= 1'b0;
      bus.core_len    <= '0;
    end else begin
      bus.core_start <= 1'b0;
      bus.core_flush <= 1'b0;
      bus.ack        <= '0;
      bus.err        <= '0;
      case (state)
        IDLE: if (pick_vld) begin
          bus.gnt         <= {{(N_CH-1){1'b0}}, 1'b1} << pick;
          ptr             <= pick;
          bus.core_mode   <= bus.cfg_mode[pick];
          bus.core_bypass <= bus.cfg_bypass[pick];
          bus.core_len    <= bus.cfg_len[int'(pick)*LEN_W +: LEN_W];
          err_flag        <= 1'b0;
          cnt             <= '0;
          state           <= START;
        end
        START: begin
          bus.core_start <= 1'b1;
          cnt            <= '0;
          state          <= WAIT_BSY;
        end
        WAIT_BSY: begin
          if (bus.core_busy) begin
            cnt   <= '0;
            state <= RUN;
          end else if (cnt == CW'(3)) begin
            err_flag       <= 1'b1;
            bus.core_flush <= 1'b1;
            state          <= FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!bus.core_mode) begin
            if (bus.core_done) begin
              bus.ack <= bus.gnt;
              state   <= DONE;
            end
`ifdef INTPOL2_SCHED_WDOG_EN
            else if (cnt == CW'(TMO - 1)) begin
              err_flag       <= 1'b1;
              bus.core_flush <= 1'b1;
              state          <= FLUSH;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end else begin
            // Stream retirement is a normal completion: no err.
            if (!own_req) begin
              bus.core_flush <= 1'b1;
              state          <= FLUSH;
            end else if (other_req) begin
              if (cnt == CW'(QUANT - 1)) begin
                bus.core_flush <= 1'b1;
                state          <= FLUSH;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          bus.ack <= bus.gnt;
          bus.err <= err_flag ? bus.gnt : '0;
          state   <= DONE;
        end
        DONE: begin
          bus.gnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/intpol2_d4_sched.md
# intpol2_D4_sched

Job scheduler that time-shares one intpol2_D4 interpolation core between N_CH requesting channels. It arbitrates round-robin, latches the winner's job configuration onto the core's control inputs, and issues the core start pulse. It tracks completion via the core's busy and done outputs, retires streaming jobs by quantum or request drop, and, when compiled in, recovers hung jobs with a watchdog. It sits between the channel register banks and the core FSM/datapath.

## Interface
- N_CH, 2: number of requesting channels (2..8).
- LEN_W, 16: job length field width.
- QUANT, 1024: stream-job time slice in cycles, counted only while another channel requests.
- TMO, 4096: watchdog limit in cycles for accelerator jobs.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  N_CH  per-channel job request, level; held until ack.
- cfg_mode  in  N_CH  per-channel mode: 0 = accelerator, 1 = stream.
- cfg_bypass  in  N_CH  per-channel bypass.
- cfg_len  in  N_CH*LEN_W  per-channel job length; channel i occupies bits [i*LEN_W +: LEN_W].
- core_busy  in  1  core busy.
- core_done  in  1  core done pulse.
- gnt  out  N_CH  one-hot grant, held for the whole job.
- ack  out  N_CH  one-cycle completion pulse to the granted channel.
- err  out  N_CH  one-cycle pulse, concurrent with ack, when the job ended abnormally.
- core_start  out  1  one-cycle start pulse to the core.
- core_mode, core_bypass  out  1 each  latched job configuration.
- core_len  out  LEN_W  latched job length.
- core_flush  out  1  one-cycle synchronous soft reset to the core; returns the core to IDLE.

## Operation
- Reset values: gnt, ack, err, core_start, core_flush, core_mode, core_bypass and core_len are all 0. The round-robin pointer resets to N_CH-1, so channel 0 has first priority. State resets to IDLE.
- IDLE: if req is nonzero, grant the first requesting channel strictly after the pointer, wrapping around. Latch that channel's cfg into the core_* registers, assert gnt, and go to START. The pointer updates to the granted channel.
- START: core_start=1 for exactly one cycle, then go to WAIT_BSY. Never hold core_start longer; a held start parks the core in its clear state.
- WAIT_BSY: wait for core_busy=1, then go to RUN. If busy has not risen within 4 cycles, go to FLUSH with err set.
- RUN, accelerator job (mode 0, with or without bypass): a core_done pulse goes to DONE.
- RUN, stream job (mode 1):
  - Go to FLUSH when the granted channel's req drops.
  - Go to FLUSH when the quantum counter reaches QUANT while any other req bit is set. The counter counts only while another req is pending and clears on grant.
  - A stream-job retirement is normal completion, with err=0.
- FLUSH: core_flush=1 for one cycle, then go to DONE.
- DONE: pulse ack (and err if flagged) for the granted channel, clear gnt, return to IDLE. A new job can be granted in the following cycle.
- Configuration inputs are sampled only in IDLE. Changes during a job have no effect.
- A channel that drops req before its grant is simply not served. A drop during an accelerator job is ignored; the job runs to done.
- core_done arriving outside RUN is ignored.
- Simultaneous core_done and watchdog expiry: done wins, err=0.
- Reset mid-job: every output returns to its reset value in the next cycle. The top must also reset the core.

## Timing
- Grant latency: req rising in IDLE gives gnt in the next cycle and core_start in the cycle after that.
- Completion latency:
  - core_done at cycle t gives ack at t+1.
  - A stream retirement trigger at t gives core_flush at t+1 and ack at t+2.
- Minimum spacing between consecutive core_start pulses is 5 cycles.
- Channel count and length are fixed by parameters; there is no runtime width change. The quantum and watchdog counters are $clog2(max(QUANT,TMO))+1 bits wide.

## Configuration
- INTPOL2_SCHED_WDOG_EN
  - Defined: accelerator jobs in RUN count cycles. Reaching TMO with no core_done goes to FLUSH with err set for that job.
  - Undefined: no watchdog counter, and accelerator jobs wait indefinitely for core_done. The WAIT_BSY 4-cycle check and its err remain in both builds.

## Test plan
- Channel 0 only, mode 0, len 8; core_done 20 cycles after start -> gnt=01 one cycle after req, a single core_start, ack[0] one cycle after done, err=0.
- req=11 held, both mode 0 -> grant order 0, 1, 0, 1; each core_start is preceded by the previous ack; no gnt overlap.
- Channel 0 in stream mode, QUANT=16; channel 1 raises req mid-stream -> core_flush after 16 cycles of contention, ack[0] one cycle later with err=0, channel 1 granted the following cycle.
- WDOG_EN build, TMO=64, core never pulses done -> core_flush at cycle 64 of RUN, then ack[0] and err[0] together. Non-WDOG build, same stimulus -> no ack by cycle 1000.
- core_busy held at 0 after start -> core_flush after 4 cycles, err pulsed.
- rst asserted during RUN -> all outputs 0 on the next edge; after release, channel 0 wins a simultaneous req=11.
